// File: rtl/cbd_sched_pkg.sv
// Shared types for the CBD sampler scheduler: polynomial, job descriptor, sizing constants.
package cbd_sched_pkg;
    localparam int ML_KEM_K  = 2;
    localparam int ML_KEM_N  = 256;
    localparam int COEF_W    = 12;
    localparam int CBD_NREQ  = 2;
    localparam int CBD_CNT_W = 4;
    localparam int CBD_ID_W  = $clog2(CBD_NREQ);

    typedef logic [ML_KEM_N-1:0][COEF_W-1:0] poly_t;

    typedef struct packed {
        logic [255:0]           seed;
        logic [7:0]             nonce;
        logic [CBD_CNT_W-1:0]   count;
        logic                   eta;
        logic [CBD_ID_W-1:0]    id;
    } cbd_job_t;
endpackage

// File: rtl/cbd_sched_if.sv
// Requester, sampler and output-stream signals of the CBD scheduler; slave = scheduler side.
interface cbd_sched_if
    import cbd_sched_pkg::*;
#(
    parameter int NREQ  = CBD_NREQ,
    parameter int CNT_W = CBD_CNT_W
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]                req_i;
    logic [NREQ-1:0][255:0]         seed_i;
    logic [NREQ-1:0][7:0]           nonce_i;
    logic [NREQ-1:0][CNT_W-1:0]     count_i;
    logic [NREQ-1:0]                eta_i;
    logic [NREQ-1:0]                gnt_o;
    logic [NREQ-1:0]                job_done_o;
    logic                           busy_o;
    logic                           cbd_run_o;
    logic [255:0]                   cbd_seed_o;
    logic [7:0]                     cbd_N_o;
    logic                           cbd_eta_o;
    logic                           cbd_done_i;
    poly_t                          cbd_poly_i;
    logic                           poly_valid_o;
    logic                           poly_ready_i;
    poly_t                          poly_o;
    logic [ID_W-1:0]                poly_src_o;
    logic [CNT_W-1:0]               poly_idx_o;

    modport slave (
        input  req_i, seed_i, nonce_i, count_i, eta_i, cbd_done_i, cbd_poly_i, poly_ready_i,
        output gnt_o, job_done_o, busy_o, cbd_run_o, cbd_seed_o, cbd_N_o, cbd_eta_o,
               poly_valid_o, poly_o, poly_src_o, poly_idx_o
    );

    modport master (
        output req_i, seed_i, nonce_i, count_i, eta_i, cbd_done_i, cbd_poly_i, poly_ready_i,
        input  gnt_o, job_done_o, busy_o, cbd_run_o, cbd_seed_o, cbd_N_o, cbd_eta_o,
               poly_valid_o, poly_o, poly_src_o, poly_idx_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request strictly after 'last', wrapping. Combinational, one-hot grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  last,
    output logic [N-1:0]          gnt
);
    always_comb begin
        gnt = '0;
        for (int i = 1; i <= N; i++) begin
            if (gnt == '0 && req[(int'(last) + i) % N]) begin
                gnt[(int'(last) + i) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cbd_sched.sv
// Shares one CBD sampler among NREQ requesters: one run per poly, nonce = base + idx,
// results held in a one-entry valid/ready register; a run is issued only when that register is free.
module cbd_sched
    import cbd_sched_pkg::*;
#(
    parameter int NREQ  = CBD_NREQ,
    parameter int CNT_W = CBD_CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    cbd_sched_if.slave  bus
);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t             state;
    cbd_job_t           job;
    logic [CNT_W-1:0]   idx;
    logic [ID_W-1:0]    last_gnt;
    logic [NREQ-1:0]    arb_gnt;
    logic [ID_W-1:0]    win_id;
    logic               out_free;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req  (bus.req_i),
        .last (last_gnt),
        .gnt  (arb_gnt)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) win_id = ID_W'(i);
        end
    end

    assign out_free       = !bus.poly_valid_o || bus.poly_ready_i;
    assign bus.busy_o     = (state != IDLE);
    assign bus.cbd_seed_o = job.seed;
    assign bus.cbd_eta_o  = job.eta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            job              <= '0;
            idx              <= '0;
            last_gnt         <= ID_W'(NREQ - 1);
            bus.gnt_o        <= '0;
            bus.job_done_o   <= '0;
            bus.cbd_run_o    <= 1'b0;
            bus.cbd_N_o      <= '0;
            bus.poly_valid_o <= 1'b0;
            bus.poly_o       <= '0;
            bus.poly_src_o   <= '0;
            bus.poly_idx_o   <= '0;
        end else begin
            bus.gnt_o      <= '0;
            bus.job_done_o <= '0;
            bus.cbd_run_o  <= 1'b0;
            if (bus.poly_valid_o && bus.poly_ready_i) bus.poly_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    // Requests are still held while gnt_o is visible; skip that cycle to avoid a double grant.
                    if (|bus.req_i && !(|bus.gnt_o)) begin
                        job.seed  <= bus.seed_i[win_id];
                        job.nonce <= bus.nonce_i[win_id];
                        job.count <= bus.count_i[win_id];
                        job.eta   <= bus.eta_i[win_id];
                        job.id    <= win_id;
                        idx       <= '0;
                        last_gnt  <= win_id;
                        bus.gnt_o <= arb_gnt;
                        if (bus.count_i[win_id] == '0) bus.job_done_o <= arb_gnt;
                        else                          state          <= ISSUE;
                    end
                end
                ISSUE, HOLD: begin
                    if (out_free) begin
                        bus.cbd_run_o <= 1'b1;
                        bus.cbd_N_o   <= job.nonce + 8'(idx);
                        state         <= WAIT;
                    end else begin
                        state <= HOLD;
                    end
                end
                WAIT: begin
                    if (bus.cbd_done_i) begin
                        bus.poly_o       <= bus.cbd_poly_i;
                        bus.poly_src_o   <= job.id;
                        bus.poly_idx_o   <= idx;
                        bus.poly_valid_o <= 1'b1;
                        idx              <= idx + CNT_W'(1);
                        if (idx + CNT_W'(1) == job.count) begin
                            bus.job_done_o <= NREQ'(1) << job.id;
                            state          <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cbd_sched.sv
// Directed bench for cbd_sched with a fixed-latency sampler model and an output-stream monitor.
module tb_cbd_sched;
    import cbd_sched_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cbd_sched_if bus ();
    cbd_sched dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    int pass_cnt = 0;
    int total_cnt = 0;

    // sampler model: done pulse LAT cycles after a run, coeff[0]=N, coeff[1]=eta
    int         mcnt = 0;
    logic [7:0] m_n;
    logic       m_e;
    poly_t      mp;
    initial begin
        bus.cbd_done_i = 1'b0;
        bus.cbd_poly_i = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.cbd_done_i = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mp = '0;
                    mp[0] = {4'h0, m_n};
                    mp[1] = {11'h0, m_e};
                    bus.cbd_poly_i = mp;
                    bus.cbd_done_i = 1'b1;
                end
            end
            if (bus.cbd_run_o === 1'b1) begin
                mcnt = LAT;
                m_n  = bus.cbd_N_o;
                m_e  = bus.cbd_eta_o;
            end
        end
    end

    // monitor, sampled mid-cycle
    int         cyc = 0;
    logic [7:0] pq_n[$];
    int         pq_src[$];
    int         pq_idx[$];
    logic       pq_eta[$];
    int         run_cnt = 0;
    int         run_cyc[$];
    logic [1:0] gnt_q[$];
    int         gnt_cyc[$];
    int         gd_same = 0;
    int         done0 = 0, done1 = 0;
    int         last_done_idx = -1;
    logic       last_done_valid = 1'b0;
    int         pulse_err = 0;
    int         rdy_rise_cyc = 0;
    int         seed_err = 0, seed_samp = 0;
    logic       seed_chk = 1'b0;
    logic [255:0] exp_seed = '0;
    logic       exp_eta = 1'b0;
    logic [1:0] prev_gnt = '0, prev_jd = '0;
    logic       prev_run = 1'b0, prev_rdy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.poly_valid_o && bus.poly_ready_i) begin
                    pq_n.push_back(bus.poly_o[0][7:0]);
                    pq_src.push_back(int'(bus.poly_src_o));
                    pq_idx.push_back(int'(bus.poly_idx_o));
                    pq_eta.push_back(bus.poly_o[1][0]);
                end
                if (bus.cbd_run_o) begin
                    run_cnt++;
                    run_cyc.push_back(cyc);
                end
                if (|bus.gnt_o) begin
                    gnt_q.push_back(bus.gnt_o);
                    gnt_cyc.push_back(cyc);
                    if (bus.job_done_o == bus.gnt_o) gd_same++;
                end
                if (bus.job_done_o[0]) done0++;
                if (bus.job_done_o[1]) done1++;
                if (|bus.job_done_o) begin
                    last_done_idx   = int'(bus.poly_idx_o);
                    last_done_valid = bus.poly_valid_o;
                end
                if ((|bus.gnt_o && |prev_gnt) || (bus.cbd_run_o && prev_run) ||
                    (|bus.job_done_o && |prev_jd)) pulse_err++;
                if (bus.poly_ready_i && !prev_rdy) rdy_rise_cyc = cyc;
                if (seed_chk && bus.busy_o) begin
                    seed_samp++;
                    if (bus.cbd_seed_o !== exp_seed || bus.cbd_eta_o !== exp_eta) seed_err++;
                end
            end
            prev_gnt = bus.gnt_o;
            prev_jd  = bus.job_done_o;
            prev_run = bus.cbd_run_o;
            prev_rdy = bus.poly_ready_i;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic submit(input int r, input logic [255:0] s, input logic [7:0] n,
                          input logic [3:0] c, input logic e, output bit ok);
        @(posedge clk); #1;
        bus.seed_i[r]  = s;
        bus.nonce_i[r] = n;
        bus.count_i[r] = c;
        bus.eta_i[r]   = e;
        bus.req_i[r]   = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.gnt_o[r]) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_i[r] = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (!bus.busy_o && !bus.poly_valid_o && mcnt == 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        bus.req_i = '0; bus.seed_i = '0; bus.nonce_i = '0; bus.count_i = '0;
        bus.eta_i = '0; bus.poly_ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.poly_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.poly_valid_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); else pass_cnt++;
        total_cnt++; if (bus.cbd_run_o !== 1'b0) $display("FAIL reset_run: got %b want 0", bus.cbd_run_o); else pass_cnt++;
        total_cnt++; if (bus.job_done_o !== 2'b00) $display("FAIL reset_done: got %b want 00", bus.job_done_o); else pass_cnt++;
        total_cnt++; if (bus.cbd_N_o !== 8'h00) $display("FAIL reset_N: got %h want 00", bus.cbd_N_o); else pass_cnt++;
        total_cnt++; if (bus.cbd_seed_o !== 256'h0) $display("FAIL reset_seed: got %h want 0", bus.cbd_seed_o); else pass_cnt++;
        total_cnt++; if (bus.poly_o !== '0) $display("FAIL reset_poly: got nonzero want 0"); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fairness;
        bit ok;
        int gs;
        gs = gnt_q.size();
        @(posedge clk); #1;
        bus.poly_ready_i = 1'b1;
        bus.count_i = {4'd1, 4'd1};
        bus.nonce_i = {8'h20, 8'h10};
        bus.req_i = 2'b11;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (gnt_q.size() >= gs + 4) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        total_cnt++; if (!ok) $display("FAIL fair_grants: got %0d grants want 4", gnt_q.size() - gs); else pass_cnt++;
        if (ok) begin
            total_cnt++; if (gnt_q[gs]   !== 2'b01) $display("FAIL fair_g0: got %b want 01", gnt_q[gs]);   else pass_cnt++;
            total_cnt++; if (gnt_q[gs+1] !== 2'b10) $display("FAIL fair_g1: got %b want 10", gnt_q[gs+1]); else pass_cnt++;
            total_cnt++; if (gnt_q[gs+2] !== 2'b01) $display("FAIL fair_g2: got %b want 01", gnt_q[gs+2]); else pass_cnt++;
            total_cnt++; if (gnt_q[gs+3] !== 2'b10) $display("FAIL fair_g3: got %b want 10", gnt_q[gs+3]); else pass_cnt++;
        end
        wait_idle(ok);
        total_cnt++; if (!ok) $display("FAIL fair_idle: got busy want idle"); else pass_cnt++;
    endtask

    task automatic test_single;
        bit ok, gok;
        int ps, rs, gs, d0;
        ps = pq_n.size(); rs = run_cyc.size(); gs = gnt_cyc.size(); d0 = done0;
        bus.poly_ready_i = 1'b1;
        submit(0, {8{32'hA5A5_0001}}, 8'h00, 4'd4, 1'b0, gok);
        wait_idle(ok);
        total_cnt++; if (!(gok && ok)) $display("FAIL single_handshake: got gnt=%b idle=%b want 1 1", gok, ok); else pass_cnt++;
        total_cnt++; if (pq_n.size() !== ps + 4) $display("FAIL single_count: got %0d want 4", pq_n.size() - ps); else pass_cnt++;
        if (pq_n.size() == ps + 4) begin
            for (int k = 0; k < 4; k++) begin
                total_cnt++; if (pq_n[ps+k] !== 8'(k)) $display("FAIL single_N%0d: got %h want %h", k, pq_n[ps+k], k); else pass_cnt++;
                total_cnt++; if (pq_idx[ps+k] !== k) $display("FAIL single_idx%0d: got %0d want %0d", k, pq_idx[ps+k], k); else pass_cnt++;
                total_cnt++; if (pq_src[ps+k] !== 0) $display("FAIL single_src%0d: got %0d want 0", k, pq_src[ps+k]); else pass_cnt++;
            end
        end
        if (run_cyc.size() > rs && gnt_cyc.size() > gs) begin
            total_cnt++; if (run_cyc[rs] - gnt_cyc[gs] !== 1) $display("FAIL single_gnt_to_run: got %0d cycles want 1", run_cyc[rs] - gnt_cyc[gs]); else pass_cnt++;
        end
        total_cnt++; if (done0 - d0 !== 1) $display("FAIL single_done_pulses: got %0d want 1", done0 - d0); else pass_cnt++;
        total_cnt++; if (last_done_idx !== 3 || last_done_valid !== 1'b1) $display("FAIL single_done_with_last: got idx %0d valid %b want 3 1", last_done_idx, last_done_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        bit ok, gok;
        int ps, r0, rs;
        ps = pq_n.size(); r0 = run_cnt; rs = run_cyc.size();
        @(posedge clk); #1;
        bus.poly_ready_i = 1'b0;
        submit(0, {8{32'hB0B0_0002}}, 8'h10, 4'd3, 1'b0, gok);
        repeat (50) @(negedge clk);
        total_cnt++; if (run_cnt - r0 !== 1) $display("FAIL bp_runs_while_full: got %0d want 1", run_cnt - r0); else pass_cnt++;
        total_cnt++; if (bus.poly_valid_o !== 1'b1) $display("FAIL bp_valid: got %b want 1", bus.poly_valid_o); else pass_cnt++;
        total_cnt++; if (bus.poly_idx_o !== 4'd0) $display("FAIL bp_idx: got %0d want 0", bus.poly_idx_o); else pass_cnt++;
        total_cnt++; if (bus.poly_o[0][7:0] !== 8'h10) $display("FAIL bp_held_N: got %h want 10", bus.poly_o[0][7:0]); else pass_cnt++;
        total_cnt++; if (pq_n.size() !== ps) $display("FAIL bp_no_transfer: got %0d want 0", pq_n.size() - ps); else pass_cnt++;
        @(posedge clk); #1;
        bus.poly_ready_i = 1'b1;
        wait_idle(ok);
        total_cnt++; if (!(gok && ok)) $display("FAIL bp_handshake: got gnt=%b idle=%b want 1 1", gok, ok); else pass_cnt++;
        total_cnt++; if (pq_n.size() !== ps + 3) $display("FAIL bp_count: got %0d want 3", pq_n.size() - ps); else pass_cnt++;
        if (pq_n.size() == ps + 3) begin
            for (int k = 0; k < 3; k++) begin
                total_cnt++; if (pq_n[ps+k] !== 8'(8'h10 + k) || pq_idx[ps+k] !== k) $display("FAIL bp_poly%0d: got N %h idx %0d want %h %0d", k, pq_n[ps+k], pq_idx[ps+k], 8'h10 + k, k); else pass_cnt++;
            end
        end
        total_cnt++; if (run_cnt - r0 !== 3) $display("FAIL bp_total_runs: got %0d want 3", run_cnt - r0); else pass_cnt++;
        if (run_cyc.size() > rs + 1) begin
            total_cnt++; if (run_cyc[rs+1] - rdy_rise_cyc !== 1) $display("FAIL bp_resume: got %0d cycles want 1", run_cyc[rs+1] - rdy_rise_cyc); else pass_cnt++;
        end
    endtask

    task automatic test_nonce_wrap;
        bit ok, gok;
        int ps;
        ps = pq_n.size();
        submit(1, {8{32'hC0C0_0003}}, 8'hFE, 4'd3, 1'b0, gok);
        wait_idle(ok);
        total_cnt++; if (pq_n.size() !== ps + 3) $display("FAIL wrap_count: got %0d want 3", pq_n.size() - ps); else pass_cnt++;
        if (pq_n.size() == ps + 3) begin
            total_cnt++; if (pq_n[ps]   !== 8'hFE) $display("FAIL wrap_N0: got %h want FE", pq_n[ps]);   else pass_cnt++;
            total_cnt++; if (pq_n[ps+1] !== 8'hFF) $display("FAIL wrap_N1: got %h want FF", pq_n[ps+1]); else pass_cnt++;
            total_cnt++; if (pq_n[ps+2] !== 8'h00) $display("FAIL wrap_N2: got %h want 00", pq_n[ps+2]); else pass_cnt++;
            total_cnt++; if (pq_src[ps+2] !== 1) $display("FAIL wrap_src: got %0d want 1", pq_src[ps+2]); else pass_cnt++;
        end
    endtask

    task automatic test_count_zero;
        bit gok;
        int g0, r0, d1;
        g0 = gd_same; r0 = run_cnt; d1 = done1;
        submit(1, {8{32'hD0D0_0004}}, 8'h33, 4'd0, 1'b0, gok);
        repeat (8) @(negedge clk);
        total_cnt++; if (gd_same - g0 !== 1) $display("FAIL zero_gnt_done_same_cycle: got %0d want 1", gd_same - g0); else pass_cnt++;
        total_cnt++; if (run_cnt - r0 !== 0) $display("FAIL zero_no_run: got %0d want 0", run_cnt - r0); else pass_cnt++;
        total_cnt++; if (done1 - d1 !== 1) $display("FAIL zero_done_pulses: got %0d want 1", done1 - d1); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL zero_busy: got %b want 0", bus.busy_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait;
        bit ok, gok;
        int r0, ps;
        r0 = run_cnt;
        submit(0, {8{32'hE0E0_0005}}, 8'h40, 4'd2, 1'b0, gok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (run_cnt > r0) ok = 1'b1;
        end
        total_cnt++; if (!ok) $display("FAIL rst_mid_run_seen: got none want 1 run"); else pass_cnt++;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.busy_o !== 1'b0 || bus.cbd_run_o !== 1'b0) $display("FAIL rst_mid_busy_run: got %b %b want 0 0", bus.busy_o, bus.cbd_run_o); else pass_cnt++;
        total_cnt++; if (bus.cbd_N_o !== 8'h00 || bus.cbd_seed_o !== 256'h0) $display("FAIL rst_mid_N_seed: got N %h want 00 and seed 0", bus.cbd_N_o); else pass_cnt++;
        total_cnt++; if (bus.poly_valid_o !== 1'b0 || bus.gnt_o !== 2'b00 || bus.job_done_o !== 2'b00) $display("FAIL rst_mid_handshake: got %b %b %b want 0 00 00", bus.poly_valid_o, bus.gnt_o, bus.job_done_o); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        ps = pq_n.size();
        repeat (10) @(negedge clk);
        total_cnt++; if (pq_n.size() !== ps || bus.poly_valid_o !== 1'b0) $display("FAIL rst_late_done: got %0d polys valid %b want 0 0", pq_n.size() - ps, bus.poly_valid_o); else pass_cnt++;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL rst_late_busy: got %b want 0", bus.busy_o); else pass_cnt++;
        submit(0, {8{32'hE0E0_0006}}, 8'h55, 4'd1, 1'b0, gok);
        wait_idle(ok);
        total_cnt++; if (gnt_q[gnt_q.size()-1] !== 2'b01) $display("FAIL rst_new_grant: got %b want 01", gnt_q[gnt_q.size()-1]); else pass_cnt++;
        total_cnt++; if (pq_n.size() !== ps + 1) $display("FAIL rst_new_count: got %0d want 1", pq_n.size() - ps); else pass_cnt++;
        if (pq_n.size() == ps + 1) begin
            total_cnt++; if (pq_n[ps] !== 8'h55 || pq_idx[ps] !== 0 || pq_src[ps] !== 0) $display("FAIL rst_new_poly: got N %h idx %0d src %0d want 55 0 0", pq_n[ps], pq_idx[ps], pq_src[ps]); else pass_cnt++;
        end
    endtask

    task automatic test_seed_stability;
        bit ok, gok;
        int ps, se, ss;
        logic [255:0] s2;
        s2 = {8{32'h5EED_1234}};
        ps = pq_n.size(); se = seed_err; ss = seed_samp;
        submit(1, s2, 8'h80, 4'd3, 1'b1, gok);
        exp_seed = s2;
        exp_eta  = 1'b1;
        seed_chk = 1'b1;
        bus.seed_i[1] = ~s2;
        bus.eta_i[1]  = 1'b0;
        wait_idle(ok);
        seed_chk = 1'b0;
        total_cnt++; if (seed_samp - ss < 5) $display("FAIL seed_samples: got %0d want at least 5", seed_samp - ss); else pass_cnt++;
        total_cnt++; if (seed_err - se !== 0) $display("FAIL seed_stable: got %0d bad cycles want 0", seed_err - se); else pass_cnt++;
        total_cnt++; if (bus.cbd_seed_o !== s2) $display("FAIL seed_latched: got %h want %h", bus.cbd_seed_o, s2); else pass_cnt++;
        total_cnt++; if (pq_n.size() !== ps + 3) $display("FAIL seed_count: got %0d want 3", pq_n.size() - ps); else pass_cnt++;
        if (pq_n.size() == ps + 3) begin
            for (int k = 0; k < 3; k++) begin
                total_cnt++; if (pq_eta[ps+k] !== 1'b1 || pq_n[ps+k] !== 8'(8'h80 + k)) $display("FAIL seed_poly%0d: got eta %b N %h want 1 %h", k, pq_eta[ps+k], pq_n[ps+k], 8'h80 + k); else pass_cnt++;
            end
        end
    endtask

    task automatic test_pulses;
        total_cnt++; if (pulse_err !== 0) $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", pulse_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_nonce_wrap();
        test_count_zero();
        test_reset_mid_wait();
        test_seed_stability();
        test_pulses();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/cbd_sched.md
# cbd_sched

Round-robin scheduler that shares one `sampleCBD` polynomial sampler among `NREQ` requesters (e.g. key generation and encapsulation). Each requester submits a job of seed, base nonce, count and eta. The block issues one sampler run per polynomial with nonce = base + index, latches every sampled polynomial into a one-entry output register under valid/ready flow control, and signals job completion. It sits between the KEM top-level control and the single CBD sampler instance.

## Interface
- `NREQ`, 2, number of requesters (≥2).
- `CNT_W`, 4, width of per-job polynomial count (max 2^CNT_W−1 polys per job).
- `clk_i` in 1, the single clock.
- `rst_i` in 1, asynchronous, active-high reset.
- `req_i` in NREQ, level request; held together with job fields until the matching `gnt_o`.
- `seed_i` in NREQ×256, per-requester seed.
- `nonce_i` in NREQ×8, per-requester base nonce.
- `count_i` in NREQ×CNT_W, polynomials requested.
- `eta_i` in NREQ, 0: eta1, 1: eta2.
- `gnt_o` in-band out NREQ, one-hot 1-cycle pulse; job accepted and latched.
- `job_done_o` out NREQ, 1-cycle pulse when the job's last poly enters the output register.
- `busy_o` out 1, job active (state ≠ IDLE).
- `cbd_run_o` out 1, 1-cycle start pulse to sampler.
- `cbd_seed_o` out 256, `cbd_N_o` out 8, `cbd_eta_o` out 1, stable from `cbd_run_o` until `cbd_done_i`.
- `cbd_done_i` in 1, sampler done pulse; `cbd_poly_i` in poly_t, valid with it.
- `poly_valid_o` out 1, `poly_ready_i` in 1, output handshake.
- `poly_o` out poly_t; `poly_src_o` out $clog2(NREQ) requester id; `poly_idx_o` out CNT_W index within job.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if any `req_i`, grant round-robin winner (first set bit strictly after `last_gnt`, wrapping). Latch seed, nonce, count, eta, id; reset idx=0. Pulse `gnt_o` and update `last_gnt`. Count=0: pulse `job_done_o` in the same cycle, stay IDLE, no sampler run. Otherwise go to ISSUE.
- ISSUE: if the output register is empty, or is being consumed this cycle (`poly_valid_o && poly_ready_i`), pulse `cbd_run_o` with `cbd_N_o` = (nonce + idx) mod 256 and go to WAIT. Otherwise go to HOLD.
- HOLD: same issue condition as ISSUE; on issue go to WAIT.
- WAIT: on `cbd_done_i`, load `poly_o`/src/idx, set `poly_valid_o`, and increment idx. If idx+1 == count, pulse `job_done_o` and go to IDLE; else go to ISSUE.
- The output register is guaranteed free at `cbd_done_i`, because a run is issued only when the register is free.
- Nonce arithmetic is 8-bit with wrap: base 0xFE, count 3 → N = 0xFE, 0xFF, 0x00.
- `cbd_done_i` outside WAIT is ignored.
- Reset, asynchronous and valid at any point including mid-job, forces:
  - IDLE, `last_gnt` = NREQ−1 (requester 0 wins first).
  - All outputs 0: `poly_valid_o`=0, `poly_o`=0, `cbd_run_o`=0, `gnt_o`=0, `job_done_o`=0, `busy_o`=0, `cbd_N_o`=0, `cbd_seed_o`=0.
  - An in-flight sampler result is dropped; the sampler's own reset is driven by the parent.

## Timing
- Grant in cycle t (IDLE) → `cbd_run_o` at t+1 if the output register is free.
- `cbd_done_i` at cycle d → `poly_valid_o` high from d+1. Next `cbd_run_o` no earlier than d+1, at d+1 only if the output is free or consumed at d+1.
- Back-to-back jobs: after the last poly's `cbd_done_i` at d, next grant at d+1 earliest.
- `gnt_o`, `job_done_o`, and `cbd_run_o` are never asserted for more than one cycle each.
- A requester that drops `req_i` before grant is not served. A requester may assert the new `req_i` on the cycle after its `job_done_o`.

## Structure
- `poly_t` and `ML_KEM_K` come from `TYPES_KEM`.
- Add to `TYPES_KEM`: `cbd_job_t` struct (seed, nonce, count, eta, id).
- Sub-module `rr_arbiter` (parameter N): inputs `req`, `last`; output one-hot `gnt`, combinational.
- Output register and FSM live in `cbd_sched`.

## Test plan
- Single job: req0 with nonce 0x00, count 4, eta 0; sampler model returns poly with coeff[0]=N → polys N=0,1,2,3, idx 0..3, src 0, one `job_done_o[0]` with the 4th poly.
- Fairness: req0 and req1 held continuously, count 1 each → grants alternate 0,1,0,1. The first grant goes to 0 after reset.
- Backpressure: `poly_ready_i`=0 for 50 cycles mid-job (count 3) → exactly one poly buffered, no `cbd_run_o` while full. Resumes one cycle after ready, no loss or duplication.
- Boundaries:
  - nonce 0xFE, count 3 → N = 0xFE, 0xFF, 0x00.
  - count 0 → `gnt_o` and `job_done_o` pulse in the same cycle, no `cbd_run_o`.
- Reset mid-WAIT: assert `rst_i` asynchronously between clock edges → all outputs 0 immediately.
  - Late `cbd_done_i` after release is ignored.
  - A new req0 is served normally with N = its base nonce.
- Eta/seed stability: `seed_i` changed after grant → `cbd_seed_o`/`cbd_eta_o` hold the latched values through the whole job.
